ma_subword_unit: RTL and testbench
==================================

Name: ma_subword_unit

Overview:
- Memory-access-stage controller placed between the pipeline's MA logic and the data memory.
- Converts LW/LH/LHU/LB/LBU/SW/SH/SB requests into word-only data-memory accesses. The data memory has an asynchronous word read, a synchronous word write, and a 7-bit word index taken from addr[8:2].
- Sub-word stores use a registered read-modify-write sequence and stall the pipeline for one extra cycle.
- No combinational path exists from dm_dout to dm_din or dm_we.

Parameters:
- AW, 32, address width of req_addr and dm_addr.
- DW, 32, data width; fixed at 32, present for readability only.

Ports:
- CLK  in  1  clock; all state updates on the rising edge.
- RST  in  1  asynchronous active-high reset.
- req_valid  in  1  MA stage presents a memory instruction.
- req_we  in  1  1 = store, 0 = load.
- req_size  in  2  00 byte, 01 halfword, 10 word, 11 reserved (treated as word).
- req_unsigned  in  1  load zero-extends when 1, sign-extends when 0.
- req_addr  in  AW  byte address.
- req_wdata  in  DW  store data, right-justified (byte in [7:0], halfword in [15:0]).
- stall  out  1  freezes PC and MA inputs while 1.
- rdata  out  DW  load result, extended.
- addr_err  out  1  misaligned access flag (see Optional Feature).
- dm_we  out  1  data memory write enable.
- dm_addr  out  AW  data memory address.
- dm_din  out  DW  data memory write data.
- dm_dout  in  DW  data memory asynchronous read data.

Behaviour:
- Byte order is big-endian.
  - Byte lane n = addr[1:0]: lane 0 is [31:24], lane 3 is [7:0].
  - Halfword: addr[1]=0 selects [31:16], addr[1]=1 selects [15:0].
- State machine with states IDLE and WRITE. Reset value is IDLE.
- Registers cleared by reset: addr_q=0, merge_q=0.
- Output values in reset: stall=0, dm_we=0, dm_addr=0, dm_din=0, rdata=0, addr_err=0.
- IDLE, no request or req_valid=0:
  - dm_we=0, stall=0, dm_addr=req_addr, rdata=0.
- IDLE, load:
  - dm_addr=req_addr.
  - rdata is the selected lane of dm_dout, extended per req_unsigned, combinationally in the same cycle.
  - stall=0; no state change.
- IDLE, word store:
  - dm_we=1, dm_addr=req_addr, dm_din=req_wdata in the same cycle.
  - stall=0; total latency 1 cycle.
- IDLE, byte/halfword store:
  - dm_addr=req_addr, dm_we=0, stall=1.
  - On the clock edge: addr_q<=req_addr; merge_q<=dm_dout with the addressed lane replaced by req_wdata[7:0] or [15:0]; next state WRITE.
- WRITE:
  - dm_addr=addr_q, dm_din=merge_q, dm_we=1, stall=0.
  - Next state IDLE.
  - The request still on the inputs during WRITE is the same instruction and must not be re-decoded.
  - Total sub-word store latency is 2 cycles: exactly one stall cycle.
- Back-to-back sub-word stores each take 2 cycles. A load immediately after a sub-word store reads the merged word, because the write commits at the end of WRITE.
- req_size=11 behaves as a word access.
- RST asserted during WRITE:
  - Outputs go to reset values immediately; dm_we drops asynchronously and the write is lost.
  - State returns to IDLE.
- Only dm_addr[8:2] is meaningful to the memory; the full address is still driven.

Optional Feature:
- Macro: MA_ALIGN_CHECK_EN.
- Defined:
  - addr_err = req_valid in IDLE and misaligned: halfword with addr[0]=1, or word with addr[1:0]!=0.
  - A misaligned store never asserts dm_we and never enters WRITE.
  - A misaligned load returns rdata=0.
  - stall=0 for any misaligned access.
- Not defined:
  - addr_err is tied to 0.
  - Halfword ignores addr[0]; word ignores addr[1:0].

Test Plan:
- Reset, then LW at 0x10 with mem[4]=0x8899AABB -> rdata=0x8899AABB, stall=0, same cycle.
- SW 0xDEADBEEF at 0x20 -> dm_we=1 for 1 cycle, dm_addr=0x20; then LW 0x20 returns 0xDEADBEEF.
- mem[8]=0x11223344; SB 0xA5 at 0x21 -> cycle 1: stall=1, dm_we=0; cycle 2: dm_we=1, dm_din=0x11A53344; LB 0x21 -> 0xFFFFFFA5; LBU 0x21 -> 0x000000A5.
- SH 0x8001 at 0x22 over 0x11223344 -> written 0x11228001; LH 0x22 -> 0xFFFF8001; LHU 0x20 -> 0x00001122.
- SB at 0x21 with RST pulsed during WRITE -> dm_we falls immediately, memory stays 0x11223344, stall=0, state IDLE.
- With MA_ALIGN_CHECK_EN: SH at 0x23 -> addr_err=1, dm_we=0, stall=0; LW at 0x22 -> addr_err=1, rdata=0.

Source files
------------

// File: rtl/ma_subword_unit.sv
// MA-stage word/sub-word access controller; optional align check via `MA_ALIGN_CHECK_EN.
// Latency: loads and word stores 0 extra cycles; byte/halfword stores 2 cycles (RMW).
// Backpressure: stall held for the single IDLE cycle of a sub-word store.
module ma_subword_unit #(
  parameter int AW = 32,
  parameter int DW = 32
) (
  input  logic          CLK,
  input  logic          RST,
  input  logic          req_valid,
  input  logic          req_we,
  input  logic [1:0]    req_size,
  input  logic          req_unsigned,
  input  logic [AW-1:0] req_addr,
  input  logic [DW-1:0] req_wdata,
  output logic          stall,
  output logic [DW-1:0] rdata,
  output logic          addr_err,
  output logic          dm_we,
  output logic [AW-1:0] dm_addr,
  output logic [DW-1:0] dm_din,
  input  logic [DW-1:0] dm_dout
);

  typedef enum logic {IDLE, WRITE} state_t;

  state_t        state_q, state_d;
  logic [AW-1:0] addr_q;
  logic [DW-1:0] merge_q, merge_d;
  logic [DW-1:0] load_data;
  logic          is_byte, is_half, misaligned, sub_store;
  logic [1:0]    lane;
  logic [4:0]    byte_lsb;
  logic [7:0]    sel_byte;
  logic [15:0]   sel_half;

  assign is_byte  = (req_size == 2'b00);
  assign is_half  = (req_size == 2'b01);
  assign lane     = req_addr[1:0];
  // Big-endian: lane 0 is the most significant byte, i.e. bit offset 8*(3-lane).
  assign byte_lsb = {~lane, 3'b000};

`ifdef MA_ALIGN_CHECK_EN
  assign misaligned = (is_half && req_addr[0]) ||
                      (!is_byte && !is_half && (req_addr[1:0] != 2'b00));
`else
  assign misaligned = 1'b0;
`endif

  assign sub_store = req_valid && req_we && (is_byte || is_half) && !misaligned;

  always_comb begin
    sel_byte = dm_dout[byte_lsb +: 8];
    sel_half = req_addr[1] ? dm_dout[15:0] : dm_dout[31:16];
    if (is_byte)
      load_data = {{(DW-8){sel_byte[7] & ~req_unsigned}}, sel_byte};
    else if (is_half)
      load_data = {{(DW-16){sel_half[15] & ~req_unsigned}}, sel_half};
    else
      load_data = dm_dout;
  end

  always_comb begin
    merge_d = dm_dout;
    if (is_byte)
      merge_d[byte_lsb +: 8] = req_wdata[7:0];
    else if (req_addr[1])
      merge_d[15:0] = req_wdata[15:0];
    else
      merge_d[31:16] = req_wdata[15:0];
  end

  always_ff @(posedge CLK or posedge RST) begin
    if (RST) state_q <= IDLE;
    else     state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (sub_store) state_d = WRITE;
      WRITE:   state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // Merged word is registered so dm_dout never reaches dm_din combinationally.
  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      addr_q  <= '0;
      merge_q <= '0;
    end else if (state_q == IDLE && sub_store) begin
      addr_q  <= req_addr;
      merge_q <= merge_d;
    end
  end

  // RST gates every output so a write in flight is dropped immediately.
  always_comb begin
    stall    = 1'b0;
    rdata    = '0;
    addr_err = 1'b0;
    dm_we    = 1'b0;
    dm_addr  = '0;
    dm_din   = '0;
    if (!RST) begin
      case (state_q)
        IDLE: begin
          dm_addr  = req_addr;
          addr_err = req_valid && misaligned;
          if (req_valid && !misaligned) begin
            if (!req_we) begin
              rdata = load_data;
            end else if (sub_store) begin
              stall = 1'b1;
            end else begin
              dm_we  = 1'b1;
              dm_din = req_wdata;
            end
          end
        end
        WRITE: begin
          dm_addr = addr_q;
          dm_din  = merge_q;
          dm_we   = 1'b1;
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_ma_subword_unit.sv
// Directed bench for ma_subword_unit with a behavioural word memory and an expectation queue.
module tb_ma_subword_unit;

  logic        CLK;
  logic        RST;
  logic        req_valid;
  logic        req_we;
  logic [1:0]  req_size;
  logic        req_unsigned;
  logic [31:0] req_addr;
  logic [31:0] req_wdata;
  logic        stall;
  logic [31:0] rdata;
  logic        addr_err;
  logic        dm_we;
  logic [31:0] dm_addr;
  logic [31:0] dm_din;
  logic [31:0] dm_dout;

  logic [31:0] mem [0:127];

  typedef struct {
    string       tag;
    logic [31:0] val;
  } exp_t;

  exp_t sb[$];
  int   n_pass  = 0;
  int   n_total = 0;

  ma_subword_unit #(.AW(32), .DW(32)) dut (
    .CLK(CLK), .RST(RST),
    .req_valid(req_valid), .req_we(req_we), .req_size(req_size),
    .req_unsigned(req_unsigned), .req_addr(req_addr), .req_wdata(req_wdata),
    .stall(stall), .rdata(rdata), .addr_err(addr_err),
    .dm_we(dm_we), .dm_addr(dm_addr), .dm_din(dm_din), .dm_dout(dm_dout)
  );

  initial CLK = 1'b0;
  always #5 CLK = ~CLK;

  assign dm_dout = mem[dm_addr[8:2]];
  always @(posedge CLK) if (dm_we) mem[dm_addr[8:2]] <= dm_din;

  task automatic drive(input bit v, input bit we, input logic [1:0] sz, input bit u,
                       input logic [31:0] a, input logic [31:0] wd);
    req_valid    = v;
    req_we       = we;
    req_size     = sz;
    req_unsigned = u;
    req_addr     = a;
    req_wdata    = wd;
  endtask

  task automatic expect_v(input string tag, input logic [31:0] v);
    exp_t e;
    e.tag = tag;
    e.val = v;
    sb.push_back(e);
  endtask

  task automatic chk(input logic [31:0] obs);
    exp_t e;
    n_total = n_total + 1;
    if (sb.size() == 0) begin
      $error("FAIL scoreboard_empty observed=%h required=<queued expectation>", obs);
      return;
    end
    e = sb.pop_front();
    assert (obs === e.val) n_pass = n_pass + 1;
    else $error("FAIL %s observed=%h required=%h", e.tag, obs, e.val);
  endtask

  task automatic step();
    @(posedge CLK);
    #1;
  endtask

  initial begin
    RST = 1'b1;
    drive(1, 1, 2'b10, 0, 32'h24, 32'hCAFE0000);
    #2;
    expect_v("rst_stall", 0); expect_v("rst_dm_we", 0); expect_v("rst_dm_addr", 0);
    expect_v("rst_dm_din", 0); expect_v("rst_rdata", 0); expect_v("rst_addr_err", 0);
    chk(stall); chk(dm_we); chk(dm_addr); chk(dm_din); chk(rdata); chk(addr_err);
    step();
    RST = 1'b0;

    // Preload memory through the unit with word stores.
    drive(1, 1, 2'b10, 0, 32'h10, 32'h8899AABB);
    expect_v("sw_pre_we", 1); expect_v("sw_pre_din", 32'h8899AABB); expect_v("sw_pre_stall", 0);
    @(negedge CLK); chk(dm_we); chk(dm_din); chk(stall);
    step();
    drive(1, 1, 2'b10, 0, 32'h20, 32'h11223344);
    step();

    drive(1, 0, 2'b10, 0, 32'h10, 0);
    expect_v("lw10_rdata", 32'h8899AABB); expect_v("lw10_stall", 0); expect_v("lw10_dm_we", 0);
    @(negedge CLK); chk(rdata); chk(stall); chk(dm_we);
    step();

    drive(1, 1, 2'b10, 0, 32'h20, 32'hDEADBEEF);
    expect_v("sw20_we", 1); expect_v("sw20_addr", 32'h20); expect_v("sw20_din", 32'hDEADBEEF);
    @(negedge CLK); chk(dm_we); chk(dm_addr); chk(dm_din);
    step();
    drive(1, 0, 2'b10, 0, 32'h20, 0);
    expect_v("lw20_rdata", 32'hDEADBEEF); expect_v("lw20_dm_we", 0);
    @(negedge CLK); chk(rdata); chk(dm_we);
    step();

    drive(1, 1, 2'b10, 0, 32'h20, 32'h11223344);
    step();
    drive(1, 1, 2'b00, 0, 32'h21, 32'h000000A5);
    expect_v("sb_c1_stall", 1); expect_v("sb_c1_we", 0); expect_v("sb_c1_addr", 32'h21);
    @(negedge CLK); chk(stall); chk(dm_we); chk(dm_addr);
    step();
    expect_v("sb_c2_we", 1); expect_v("sb_c2_din", 32'h11A53344); expect_v("sb_c2_stall", 0);
    expect_v("sb_c2_addr", 32'h21);
    @(negedge CLK); chk(dm_we); chk(dm_din); chk(stall); chk(dm_addr);
    step();
    drive(1, 0, 2'b00, 0, 32'h21, 0);
    expect_v("lb21_rdata", 32'hFFFFFFA5); expect_v("sb_mem", 32'h11A53344);
    @(negedge CLK); chk(rdata); chk(mem[8]);
    step();
    drive(1, 0, 2'b00, 1, 32'h21, 0);
    expect_v("lbu21_rdata", 32'h000000A5);
    @(negedge CLK); chk(rdata);
    step();

    drive(1, 1, 2'b10, 0, 32'h20, 32'h11223344);
    step();
    drive(1, 1, 2'b01, 0, 32'h22, 32'h00008001);
    expect_v("sh_c1_stall", 1);
    @(negedge CLK); chk(stall);
    step();
    expect_v("sh_c2_din", 32'h11228001); expect_v("sh_c2_we", 1);
    @(negedge CLK); chk(dm_din); chk(dm_we);
    step();
    drive(1, 0, 2'b01, 0, 32'h22, 0);
    expect_v("lh22_rdata", 32'hFFFF8001);
    @(negedge CLK); chk(rdata);
    step();
    drive(1, 0, 2'b01, 1, 32'h20, 0);
    expect_v("lhu20_rdata", 32'h00001122);
    @(negedge CLK); chk(rdata);
    step();

    // Back-to-back sub-word stores, then a reserved-size load of the merged word.
    drive(1, 1, 2'b00, 0, 32'h20, 32'h00000077);
    expect_v("b2b1_stall", 1);
    @(negedge CLK); chk(stall);
    step();
    expect_v("b2b1_din", 32'h77228001);
    @(negedge CLK); chk(dm_din);
    step();
    drive(1, 1, 2'b00, 0, 32'h23, 32'h00000066);
    expect_v("b2b2_stall", 1); expect_v("b2b2_we", 0);
    @(negedge CLK); chk(stall); chk(dm_we);
    step();
    expect_v("b2b2_din", 32'h77228066); expect_v("b2b2_addr", 32'h23);
    @(negedge CLK); chk(dm_din); chk(dm_addr);
    step();
    drive(1, 0, 2'b11, 0, 32'h20, 0);
    expect_v("lw_sz11_rdata", 32'h77228066);
    @(negedge CLK); chk(rdata);
    step();

    // Reset in the middle of the WRITE cycle must drop the write.
    drive(1, 1, 2'b10, 0, 32'h20, 32'h11223344);
    step();
    drive(1, 1, 2'b00, 0, 32'h21, 32'h000000A5);
    step();
    expect_v("rstw_pre_we", 1);
    chk(dm_we);
    #2 RST = 1'b1;
    #1;
    expect_v("rstw_we", 0); expect_v("rstw_stall", 0); expect_v("rstw_din", 0);
    chk(dm_we); chk(stall); chk(dm_din);
    step();
    RST = 1'b0;
    drive(1, 0, 2'b10, 0, 32'h20, 0);
    expect_v("rstw_mem", 32'h11223344); expect_v("rstw_rdata", 32'h11223344);
    expect_v("rstw_idle_we", 0); expect_v("rstw_idle_stall", 0);
    @(negedge CLK); chk(mem[8]); chk(rdata); chk(dm_we); chk(stall);
    step();

`ifdef MA_ALIGN_CHECK_EN
    drive(1, 1, 2'b01, 0, 32'h23, 32'h0000BEEF);
    expect_v("mis_sh_err", 1); expect_v("mis_sh_we", 0); expect_v("mis_sh_stall", 0);
    @(negedge CLK); chk(addr_err); chk(dm_we); chk(stall);
    step();
    expect_v("mis_sh_nowrite", 0);
    @(negedge CLK); chk(dm_we);
    step();
    drive(1, 0, 2'b10, 0, 32'h22, 0);
    expect_v("mis_lw_err", 1); expect_v("mis_lw_rdata", 0); expect_v("mis_mem", 32'h11223344);
    @(negedge CLK); chk(addr_err); chk(rdata); chk(mem[8]);
    step();
`else
    drive(1, 1, 2'b01, 0, 32'h23, 32'h0000BEEF);
    expect_v("sh23_err", 0); expect_v("sh23_stall", 1);
    @(negedge CLK); chk(addr_err); chk(stall);
    step();
    expect_v("sh23_din", 32'h1122BEEF);
    @(negedge CLK); chk(dm_din);
    step();
    drive(1, 0, 2'b10, 0, 32'h22, 0);
    expect_v("lw22_rdata", 32'h1122BEEF); expect_v("lw22_err", 0);
    @(negedge CLK); chk(rdata); chk(addr_err);
    step();
`endif

    drive(0, 0, 2'b10, 0, 32'h44, 0);
    expect_v("idle_rdata", 0); expect_v("idle_we", 0); expect_v("idle_stall", 0);
    expect_v("idle_addr", 32'h44);
    @(negedge CLK); chk(rdata); chk(dm_we); chk(stall); chk(dm_addr);
    step();

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
